// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode constants: stall encoding, stall-vector stage indices,
// and the default bubble (reboot address / NOP) values.
package if_id_queue_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int IF_STAGE = 1;
    localparam int ID_STAGE = 2;

    localparam logic [31:0] DEF_REBOOT_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST    = 32'h0000_0013;

endpackage

// File: rtl/if_id_fifo_mem.sv
// Fetch-buffer storage: one synchronous write port, asynchronous read at rd_addr.
// No reset; validity is tracked entirely by the pointers in the parent.
module if_id_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID fetch buffer with registered decode output; 1-cycle latency via bypass when empty.
// Backpressure: in_ready deasserts when full (no enqueue-on-full even with a same-cycle dequeue).
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] REBOOT_ADDR = ADDR_WIDTH'(DEF_REBOOT_ADDR),
    parameter logic [DATA_WIDTH-1:0] NOP_INST    = DATA_WIDTH'(DEF_NOP_INST)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_WIDTH-1:0]      inst_addr_i,
    input  logic [DATA_WIDTH-1:0]      inst_i,
    input  logic [5:0]                 stall_i,
    input  logic                       flush_jump_i,
    input  logic                       flush_int_i,
    output logic [ADDR_WIDTH-1:0]      inst_addr_o,
    output logic [DATA_WIDTH-1:0]      inst_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int W  = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] rptr, wptr;
    logic [CW-1:0] count;
    logic [W-1:0]  rd_data;
    logic          flush, acc, adv, deq, bypass, wr_en;

    // Only the IF and ID stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall_i[5:3], stall_i[0]};

    assign flush      = flush_jump_i | flush_int_i;
    assign in_ready_o = (count != FULL);
    assign acc        = in_valid_i & in_ready_o & (stall_i[IF_STAGE] == NOSTOP) & ~flush;
    assign adv        = (stall_i[ID_STAGE] == NOSTOP);
    assign deq        = adv & (count != '0) & ~flush;
    // Empty queue and decode advancing: skip the RAM so latency matches a plain register.
    assign bypass     = adv & (count == '0) & acc;
    assign wr_en      = acc & ~bypass & ~rst_i;
    assign count_o    = count;

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_mem (
        .clk_i   (clk_i),
        .wr_en   (wr_en),
        .wr_addr (wptr),
        .wr_data ({inst_addr_i, inst_i}),
        .rd_addr (rptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inst_addr_o <= REBOOT_ADDR;
            inst_o      <= NOP_INST;
            valid_o     <= 1'b0;
            count       <= '0;
            rptr        <= '0;
            wptr        <= '0;
        end else if (flush) begin
            inst_addr_o <= REBOOT_ADDR;
            inst_o      <= NOP_INST;
            valid_o     <= 1'b0;
            count       <= '0;
            rptr        <= wptr;
        end else begin
            if (adv) begin
                if (deq) begin
                    {inst_addr_o, inst_o} <= rd_data;
                    valid_o               <= 1'b1;
                    rptr                  <= rptr + PW'(1);
                end else if (bypass) begin
                    inst_addr_o <= inst_addr_i;
                    inst_o      <= inst_i;
                    valid_o     <= 1'b1;
                end else begin
                    inst_addr_o <= REBOOT_ADDR;
                    inst_o      <= NOP_INST;
                    valid_o     <= 1'b0;
                end
            end
            if (wr_en) begin
                wptr <= wptr + PW'(1);
            end
            count <= count + CW'(wr_en) - CW'(deq);
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: bypass, fill/drain, flush, IF stall, pointer wrap, mid-run reset.
module tb_if_id_queue;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] addr_in = '0;
    logic [31:0] inst_in = '0;
    logic [5:0]  stall = '0;
    logic        flush_jump = 1'b0;
    logic        flush_int = 1'b0;
    logic [31:0] addr_out;
    logic [31:0] inst_out;
    logic        valid_out;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_id_queue dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .inst_addr_i  (addr_in),
        .inst_i       (inst_in),
        .stall_i      (stall),
        .flush_jump_i (flush_jump),
        .flush_int_i  (flush_int),
        .inst_addr_o  (addr_out),
        .inst_o       (inst_out),
        .valid_o      (valid_out),
        .count_o      (count)
    );

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a);
        in_valid = 1'b1;
        addr_in  = a;
        inst_in  = mk_inst(a);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (addr_out !== BOOT) begin bad++; $display("FAIL reset_addr got=%h exp=%h", addr_out, BOOT); end
        total++; if (inst_out !== NOP) begin bad++; $display("FAIL reset_inst got=%h exp=%h", inst_out, NOP); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h100 + 32'(4 * i);
            offer(a);
            tick();
            total++; if (addr_out !== a || inst_out !== mk_inst(a) || valid_out !== 1'b1)
                begin bad++; $display("FAIL bypass_%0d got=%h/%h/%b exp=%h/%h/1", i, addr_out, inst_out, valid_out, a, mk_inst(a)); end
            total++; if (count !== 3'd0) begin bad++; $display("FAIL bypass_count_%0d got=%0d exp=0", i, count); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (valid_out !== 1'b0 || inst_out !== NOP) begin bad++; $display("FAIL bypass_bubble got=%b/%h exp=0/%h", valid_out, inst_out, NOP); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_addr [5];
        logic [2:0]  exp_cnt  [5];
        exp_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210};
        exp_cnt  = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        stall = 6'b000100;
        for (int i = 0; i < 5; i++) begin
            offer(32'h200 + 32'(4 * i));
            total++; if (in_ready !== (i < 4)) begin bad++; $display("FAIL fill_ready_%0d got=%b exp=%b", i, in_ready, (i < 4)); end
            tick();
            total++; if (count !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin bad++; $display("FAIL fill_count_%0d got=%0d", i, count); end
        end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL fill_hold_valid got=%b exp=0", valid_out); end
        stall = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) in_valid = 1'b0;
            total++; if (addr_out !== exp_addr[i] || inst_out !== mk_inst(exp_addr[i]) || valid_out !== 1'b1)
                begin bad++; $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, addr_out, valid_out, exp_addr[i]); end
            total++; if (count !== exp_cnt[i]) begin bad++; $display("FAIL drain_count_%0d got=%0d exp=%0d", i, count, exp_cnt[i]); end
            if (i == 0) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b exp=1", in_ready); end
            end
        end
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL drain_bubble got=%b exp=0", valid_out); end
    endtask

    task automatic test_flush();
        stall = 6'b000100;
        offer(32'h300); tick();
        offer(32'h304); tick();
        total++; if (count !== 3'd2) begin bad++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
        offer(32'h308);
        flush_jump = 1'b1;
        tick();
        flush_jump = 1'b0;
        in_valid   = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (addr_out !== BOOT || inst_out !== NOP || valid_out !== 1'b0)
            begin bad++; $display("FAIL flush_out got=%h/%h/%b exp=%h/%h/0", addr_out, inst_out, valid_out, BOOT, NOP); end
        stall = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (valid_out !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL flush_leak_%0d got=%h/%b cnt=%0d exp=bubble", i, addr_out, valid_out, count); end
        end
        // Interrupt flush on a pending bypass must also drop it.
        offer(32'h30C);
        flush_int = 1'b1;
        tick();
        flush_int = 1'b0;
        in_valid  = 1'b0;
        total++; if (valid_out !== 1'b0 || addr_out !== BOOT) begin bad++; $display("FAIL flush_int got=%h/%b exp=%h/0", addr_out, valid_out, BOOT); end
    endtask

    task automatic test_if_stall();
        stall = 6'b000010;
        offer(32'h400);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (valid_out !== 1'b0 || inst_out !== NOP || count !== 3'd0)
                begin bad++; $display("FAIL ifstall_%0d got=%h/%b cnt=%0d exp=%h/0/0", i, inst_out, valid_out, count, NOP); end
        end
        stall = 6'b000000;
        tick();
        in_valid = 1'b0;
        total++; if (addr_out !== 32'h400 || valid_out !== 1'b1) begin bad++; $display("FAIL ifstall_release got=%h/%b exp=400/1", addr_out, valid_out); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_q [$];
        logic [31:0] next_a;
        logic        adv_now, acc_now;
        int          delivered;
        next_a    = 32'h1000;
        delivered = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 80; cyc++) begin
            stall    = {3'b000, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 2'b00};
            in_valid = (cyc < 50) ? ($urandom_range(0, 3) != 0) : 1'b0;
            addr_in  = next_a;
            inst_in  = mk_inst(next_a);
            adv_now  = !stall[2];
            acc_now  = in_valid && in_ready;
            if (acc_now) begin
                exp_q.push_back(next_a);
                next_a = next_a + 32'h4;
            end
            tick();
            if (adv_now && valid_out) begin
                logic [31:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                delivered++;
                total++; if (addr_out !== e || inst_out !== mk_inst(e)) begin bad++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", cyc, addr_out, e); end
            end else if (adv_now) begin
                total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_bubble cyc=%0d pending=%0d exp=0", cyc, exp_q.size()); end
            end
            total++; if (int'(count) != exp_q.size()) begin bad++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, count, exp_q.size()); end
        end
        stall    = '0;
        in_valid = 1'b0;
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            tick();
            delivered++;
            total++; if (addr_out !== e || valid_out !== 1'b1) begin bad++; $display("FAIL wrap_drain got=%h/%b exp=%h/1", addr_out, valid_out, e); end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_leftover got=%0d exp=0", exp_q.size()); end
        total++; if (delivered < 12) begin bad++; $display("FAIL wrap_volume got=%0d exp>=12", delivered); end
        tick();
    endtask

    task automatic test_reset_mid();
        stall = 6'b000000;
        offer(32'h600); tick();
        stall = 6'b000100;
        offer(32'h604); tick();
        offer(32'h608); tick();
        offer(32'h60C); tick();
        in_valid = 1'b0;
        total++; if (count !== 3'd3 || valid_out !== 1'b1 || addr_out !== 32'h600)
            begin bad++; $display("FAIL rstmid_pre got=%h/%b cnt=%0d exp=600/1/3", addr_out, valid_out, count); end
        rst = 1'b1;
        offer(32'h6FC);
        tick();
        rst = 1'b0;
        total++; if (addr_out !== BOOT || inst_out !== NOP || valid_out !== 1'b0 || count !== 3'd0)
            begin bad++; $display("FAIL rstmid_out got=%h/%h/%b cnt=%0d exp=%h/%h/0/0", addr_out, inst_out, valid_out, count, BOOT, NOP); end
        stall = 6'b000000;
        offer(32'h700);
        tick();
        in_valid = 1'b0;
        total++; if (addr_out !== 32'h700 || inst_out !== mk_inst(32'h700) || valid_out !== 1'b1 || count !== 3'd0)
            begin bad++; $display("FAIL rstmid_first got=%h/%b cnt=%0d exp=700/1/0", addr_out, valid_out, count); end
        tick();
        total++; if (valid_out !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL rstmid_stale got=%h/%b exp=bubble", addr_out, valid_out); end
    endtask

    initial begin
        tick();
        test_reset();
        test_bypass();
        test_fill_drain();
        test_flush();
        test_if_stall();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
